midi_voice_allocator: RTL and testbench

Parametrised polyphonic voice allocator that sits between the MIDI framer (midi_uart) and an array of NUM_VOICES voice instances.
- Decodes note-on, note-off, sustain pedal (CC 64) and all-notes-off (CC 123) events.
- Assigns notes to voices by preferring idle voices, then stealing the oldest voice.
- Forces a gate-low retrigger gap so envelopes restart correctly.
- Drives per-voice gate, note and velocity; the top level maps note to tone frequency.

---
 rtl/midi_voice_allocator.sv | 232 +++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: decodes framed MIDI events and maps notes onto
// NUM_VOICES voices, reusing same-note voices, then idle voices, then stealing the oldest.
module midi_voice_allocator #(
  parameter int NUM_VOICES    = 8,
  parameter int MIDI_CHANNEL  = 0,
  parameter int OMNI          = 0,
  parameter int RETRIG_CYCLES = 400,
  parameter int AGE_BITS      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    midi_event_valid,
  input  logic [7:0]              midi_command,
  input  logic [6:0]              midi_parameter_1,
  input  logic [6:0]              midi_parameter_2,
  output logic                    midi_event_ack,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic                    voice_stolen
);

  // state  | meaning
  // IDLE   | waiting for midi_event_valid, latches the event
  // DECIDE | decode event, pick target voice / note-off match mask
  // APPLY  | update voice state, ack pulse high
  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(RETRIG_CYCLES + 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX     = '1;
  localparam logic [CW-1:0]       RETRIG_LOAD = CW'(RETRIG_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_APPLY} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ON, OP_OFF, OP_PED_DN, OP_PED_UP, OP_ALL_OFF} op_t;

  state_t                r_state;
  op_t                   r_op;
  logic [7:0]            r_cmd;
  logic [6:0]            r_p1;
  logic [6:0]            r_p2;
  logic [IW-1:0]         r_tgt;
  logic [NUM_VOICES-1:0] r_off_mask;
  logic                  r_ack;
  logic                  r_stolen;
  logic                  r_pedal_down;
  logic [NUM_VOICES-1:0] r_gate;
  logic [NUM_VOICES-1:0] r_sus;
  logic [6:0]            r_note [NUM_VOICES];
  logic [6:0]            r_vel  [NUM_VOICES];
  logic [AGE_BITS-1:0]   r_age  [NUM_VOICES];
  logic [CW-1:0]         r_cnt  [NUM_VOICES];

  op_t                   w_op;
  logic                  w_chan_ok;
  logic [NUM_VOICES-1:0] w_busy;
  logic [NUM_VOICES-1:0] w_off_mask;
  logic                  w_hit;
  logic [IW-1:0]         w_hit_idx;
  logic                  w_idle_found;
  logic [IW-1:0]         w_idle_idx;
  logic [AGE_BITS-1:0]   w_idle_age;
  logic [IW-1:0]         w_old_idx;
  logic [AGE_BITS-1:0]   w_old_age;
  logic [IW-1:0]         w_tgt;
  logic                  w_steal;

  always_comb begin
    w_op      = OP_NONE;
    w_chan_ok = (OMNI != 0) || (r_cmd[3:0] == 4'(MIDI_CHANNEL));
    if (w_chan_ok) begin
      case (r_cmd[7:4])
        4'h9: w_op = (r_p2 != 7'd0) ? OP_ON : OP_OFF;
        4'h8: w_op = OP_OFF;
        4'hB: begin
          if (r_p1 == 7'd64)       w_op = r_p2[6] ? OP_PED_DN : OP_PED_UP;
          else if (r_p1 == 7'd123) w_op = OP_ALL_OFF;
        end
        default: w_op = OP_NONE;
      endcase
    end
  end

  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    w_busy       = '0;
    w_off_mask   = '0;
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_idle_found = 1'b0;
    w_idle_idx   = '0;
    w_idle_age   = '0;
    w_old_idx    = '0;
    w_old_age    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_busy[i]     = r_gate[i] || r_sus[i] || (r_cnt[i] != '0);
      w_off_mask[i] = (r_note[i] == r_p1) && (r_gate[i] || (r_cnt[i] != '0));
      if (!w_hit && w_busy[i] && (r_note[i] == r_p1)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (!w_busy[i] && (!w_idle_found || (r_age[i] > w_idle_age))) begin
        w_idle_found = 1'b1;
        w_idle_idx   = IW'(i);
        w_idle_age   = r_age[i];
      end
      if ((i == 0) || (r_age[i] > w_old_age)) begin
        w_old_idx = IW'(i);
        w_old_age = r_age[i];
      end
    end
    w_steal = !w_hit && !w_idle_found;
    w_tgt   = w_hit ? w_hit_idx : (w_idle_found ? w_idle_idx : w_old_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_NONE;
      r_cmd        <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_tgt        <= '0;
      r_off_mask   <= '0;
      r_ack        <= 1'b0;
      r_stolen     <= 1'b0;
      r_pedal_down <= 1'b0;
      r_gate       <= '0;
      r_sus        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_age[i]  <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_ack    <= 1'b0;
      r_stolen <= 1'b0;
      // Retrigger countdown; APPLY below overrides for voices it touches.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
          if (r_cnt[i] == CW'(1)) r_gate[i] <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (midi_event_valid) begin
            r_cmd   <= midi_command;
            r_p1    <= midi_parameter_1;
            r_p2    <= midi_parameter_2;
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          r_op       <= w_op;
          r_tgt      <= w_tgt;
          r_off_mask <= w_off_mask;
          r_ack      <= 1'b1;
          r_stolen   <= (w_op == OP_ON) && w_steal;
          r_state    <= S_APPLY;
        end
        S_APPLY: begin
          r_state <= S_IDLE;
          case (r_op)
            OP_ON: begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (r_tgt == IW'(i)) begin
                  r_note[i] <= r_p1;
                  r_vel[i]  <= r_p2;
                  r_sus[i]  <= 1'b0;
                  r_age[i]  <= '0;
                  if (r_gate[i] || (r_cnt[i] != '0)) begin
                    r_gate[i] <= 1'b0;
                    r_cnt[i]  <= RETRIG_LOAD;
                  end else begin
                    r_gate[i] <= 1'b1;
                    r_cnt[i]  <= '0;
                  end
                end else if (r_age[i] != AGE_MAX) begin
                  r_age[i] <= r_age[i] + AGE_BITS'(1);
                end
              end
            end
            OP_OFF: begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (r_off_mask[i]) begin
                  if (r_pedal_down) begin
                    r_sus[i] <= 1'b1;
                  end else begin
                    r_gate[i] <= 1'b0;
                    r_cnt[i]  <= '0;
                  end
                end
              end
            end
            OP_PED_DN: r_pedal_down <= 1'b1;
            OP_PED_UP: begin
              r_pedal_down <= 1'b0;
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (r_sus[i]) begin
                  r_gate[i] <= 1'b0;
                  r_sus[i]  <= 1'b0;
                  r_cnt[i]  <= '0;
                end
              end
            end
            OP_ALL_OFF: begin
              r_gate <= '0;
              r_sus  <= '0;
              for (int i = 0; i < NUM_VOICES; i++) r_cnt[i] <= '0;
            end
            default: ;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    voice_note     = '0;
    voice_velocity = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7]     = r_note[i];
      voice_velocity[7*i +: 7] = r_vel[i];
    end
  end

  assign midi_event_ack = r_ack;
  assign voice_stolen   = r_stolen;
  assign voice_gate     = r_gate;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with four voices and a 400-cycle retrigger gap.
module tb_midi_voice_allocator;

  localparam int NV = 4;
  localparam int RT = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          midi_event_valid = 1'b0;
  logic [7:0]    midi_command = '0;
  logic [6:0]    midi_parameter_1 = '0;
  logic [6:0]    midi_parameter_2 = '0;
  logic          midi_event_ack;
  logic [NV-1:0] voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_velocity;
  logic          voice_stolen;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic stl;
  logic ack_seen;

  midi_voice_allocator #(
    .NUM_VOICES(NV), .MIDI_CHANNEL(0), .OMNI(0), .RETRIG_CYCLES(RT), .AGE_BITS(8)
  ) dut (
    .clk(clk), .rst(rst),
    .midi_event_valid(midi_event_valid), .midi_command(midi_command),
    .midi_parameter_1(midi_parameter_1), .midi_parameter_2(midi_parameter_2),
    .midi_event_ack(midi_event_ack), .voice_gate(voice_gate),
    .voice_note(voice_note), .voice_velocity(voice_velocity),
    .voice_stolen(voice_stolen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one event, wait (bounded) for ack, then return one cycle after APPLY.
  task automatic send(input logic [7:0] cmd, input logic [6:0] p1, input logic [6:0] p2,
                      output int latency, output logic stolen);
    @(negedge clk);
    midi_command     = cmd;
    midi_parameter_1 = p1;
    midi_parameter_2 = p2;
    midi_event_valid = 1'b1;
    latency = -1;
    stolen  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (midi_event_ack) begin
        latency = k;
        stolen  = voice_stolen;
        break;
      end
    end
    midi_event_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    chk("rst_gate", voice_gate, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_vel", voice_velocity, 0);
    chk("rst_ack", midi_event_ack, 0);
    chk("rst_stolen", voice_stolen, 0);
    @(negedge clk); rst = 1'b0;

    send(8'h90, 7'd60, 7'd100, lat, stl);
    chk("on60_lat", lat, 2);
    chk("on60_stolen", stl, 0);
    chk("on60_ack_pulse", midi_event_ack, 0);
    chk("on60_gate", voice_gate, 4'b0001);
    chk("on60_note", voice_note[6:0], 60);
    chk("on60_vel", voice_velocity[6:0], 100);

    send(8'h90, 7'd62, 7'd80, lat, stl);
    send(8'h90, 7'd64, 7'd80, lat, stl);
    send(8'h90, 7'd65, 7'd80, lat, stl);
    chk("fill_gate", voice_gate, 4'b1111);
    chk("fill_notes", voice_note, {7'd65, 7'd64, 7'd62, 7'd60});
    chk("fill_stolen", stl, 0);

    send(8'h90, 7'd67, 7'd48, lat, stl);
    chk("steal_lat", lat, 2);
    chk("steal_pulse", stl, 1);
    chk("steal_gate_low", voice_gate, 4'b1110);
    cycles(RT - 1);
    chk("steal_gate_still_low", voice_gate, 4'b1110);
    cycles(1);
    chk("steal_gate_high", voice_gate, 4'b1111);
    chk("steal_note", voice_note[6:0], 67);
    chk("steal_vel", voice_velocity[6:0], 48);

    send(8'hB0, 7'd123, 7'd0, lat, stl);
    chk("allnotesoff_gate", voice_gate, 4'b0000);

    // Ages now v0=0 v1=3 v2=2 v3=1: oldest idle is voice 1.
    send(8'h90, 7'd60, 7'd32, lat, stl);
    chk("re_first_gate", voice_gate, 4'b0010);
    send(8'h90, 7'd60, 7'd90, lat, stl);
    chk("re_stolen", stl, 0);
    chk("re_gate_low", voice_gate, 4'b0000);
    cycles(RT - 1);
    chk("re_gate_still_low", voice_gate, 4'b0000);
    cycles(1);
    chk("re_gate_high", voice_gate, 4'b0010);
    chk("re_vel", voice_velocity[13:7], 90);

    // Ages v0=2 v1=0 v2=4 v3=3: after all-off, next note goes to voice 2.
    send(8'hB0, 7'd123, 7'd0, lat, stl);
    send(8'hB0, 7'd64, 7'd127, lat, stl);
    send(8'h90, 7'd60, 7'd100, lat, stl);
    chk("ped_on_gate", voice_gate, 4'b0100);
    send(8'h80, 7'd60, 7'd64, lat, stl);
    chk("ped_off_held", voice_gate, 4'b0100);
    send(8'hB0, 7'd64, 7'd0, lat, stl);
    chk("ped_up_lat", lat, 2);
    chk("ped_up_gate", voice_gate, 4'b0000);

    send(8'h93, 7'd70, 7'd50, lat, stl);
    chk("chan_lat", lat, 2);
    chk("chan_gate", voice_gate, 4'b0000);
    chk("chan_note3", voice_note[27:21], 65);

    // Ages v0=3 v1=1 v2=0 v3=4: voice 3 receives note 72.
    send(8'h90, 7'd72, 7'd100, lat, stl);
    chk("v0off_on_gate", voice_gate, 4'b1000);
    send(8'h90, 7'd72, 7'd0, lat, stl);
    chk("v0off_gate", voice_gate, 4'b0000);
    chk("v0off_note_kept", voice_note[27:21], 72);
    chk("v0off_vel_kept", voice_velocity[27:21], 100);

    @(negedge clk);
    midi_command = 8'h90; midi_parameter_1 = 7'd50; midi_parameter_2 = 7'd60;
    midi_event_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_gate", voice_gate, 0);
    chk("abort_note", voice_note, 0);
    chk("abort_vel", voice_velocity, 0);
    chk("abort_ack", midi_event_ack, 0);
    midi_event_valid = 1'b0;
    ack_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (midi_event_ack) ack_seen = 1'b1;
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (midi_event_ack) ack_seen = 1'b1;
    end
    chk("abort_no_ack", ack_seen, 0);

    send(8'h90, 7'd55, 7'd70, lat, stl);
    chk("post_lat", lat, 2);
    chk("post_gate", voice_gate, 4'b0001);
    chk("post_note", voice_note[6:0], 55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
